// File: rtl/yutorina_bus_arbiter.sv
// Four-master round-robin bus arbiter with hold-time preemption that is
// suppressed while a shared-bus transfer is still in flight.
module yutorina_bus_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  input  logic       s_as_,
  input  logic       s_rdy_,
  output logic [1:0] owner,
  output logic       busy
);

  typedef enum logic {IDLE, OWNED} state_t;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

  state_t     r_state;
  state_t     w_nextState;
  logic [1:0] r_owner;
  logic [1:0] r_last;
  logic [7:0] r_hold;
  logic       r_pending;
  logic [3:0] r_grntN;
  logic       r_busy;

  logic [1:0] w_nextOwner;
  logic [1:0] w_nextLast;
  logic [7:0] w_nextHold;
  logic       w_nextPending;
  logic [3:0] w_req;
  logic [3:0] w_others;
  logic       w_othersAny;
  logic [1:0] w_idlePick;
  logic [1:0] w_otherPick;
  logic       w_preempt;

  // First asserted request scanning from (from+1) upward with wrap; the
  // last candidate tried is 'from' itself.
  function automatic logic [1:0] rrPick(input logic [3:0] req, input logic [1:0] from);
    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    pick  = from;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = from + 2'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign w_req       = ~{m3_req_, m2_req_, m1_req_, m0_req_};
  assign w_others    = w_req & ~(4'b0001 << r_owner);
  assign w_othersAny = |w_others;
  assign w_idlePick  = rrPick(w_req, r_last);
  assign w_otherPick = rrPick(w_others, r_owner);
  assign w_preempt   = (r_hold >= HOLD_LIMIT) && w_othersAny && !r_pending && s_as_;

  always_comb begin
    w_nextState   = r_state;
    w_nextOwner   = r_owner;
    w_nextLast    = r_last;
    w_nextHold    = r_hold;
    w_nextPending = !s_rdy_ ? 1'b0 : (!s_as_ ? 1'b1 : r_pending);
    case (r_state)
      IDLE: begin
        if (|w_req) begin
          w_nextState = OWNED;
          w_nextOwner = w_idlePick;
          w_nextLast  = w_idlePick;
          w_nextHold  = 8'd0;
        end
      end
      OWNED: begin
        // Release outranks preemption; both hand over without a dead cycle.
        if (!w_req[r_owner]) begin
          w_nextHold = 8'd0;
          if (w_othersAny) begin
            w_nextOwner = w_otherPick;
            w_nextLast  = w_otherPick;
          end else begin
            w_nextState = IDLE;
          end
        end else if (w_preempt) begin
          w_nextOwner = w_otherPick;
          w_nextLast  = w_otherPick;
          w_nextHold  = 8'd0;
        end else if (r_hold != 8'hFF) begin
          w_nextHold = r_hold + 8'd1;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_owner   <= 2'd0;
      r_last    <= 2'd3;
      r_hold    <= 8'd0;
      r_pending <= 1'b0;
      r_grntN   <= 4'hF;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_owner   <= w_nextOwner;
      r_last    <= w_nextLast;
      r_hold    <= w_nextHold;
      r_pending <= w_nextPending;
      r_grntN   <= (w_nextState == OWNED) ? ~(4'b0001 << w_nextOwner) : 4'hF;
      r_busy    <= (w_nextState == OWNED);
    end
  end

  assign m0_grnt_ = r_grntN[0];
  assign m1_grnt_ = r_grntN[1];
  assign m2_grnt_ = r_grntN[2];
  assign m3_grnt_ = r_grntN[3];
  assign owner    = r_owner;
  assign busy     = r_busy;

endmodule

// File: tb/tb_yutorina_bus_arbiter.sv
// Directed bench for yutorina_bus_arbiter: a cycle model of the arbitration
// rules checked every cycle, plus literal expectations at key points.
module tb_yutorina_bus_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic [3:0] reqN = 4'hF;
  logic       asN = 1'b1;
  logic       rdyN = 1'b1;
  logic       g0, g1, g2, g3;
  logic [1:0] dutOwner;
  logic       dutBusy;
  logic [3:0] grantN;

  int totalCount = 0;
  int badCount = 0;
  bit chkEn = 1'b0;

  bit mBusy = 1'b0;
  int mOwner = 0;
  int mLast = 3;
  int mHold = 0;
  bit mPending = 1'b0;

  yutorina_bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rstN),
    .m0_req_(reqN[0]), .m1_req_(reqN[1]), .m2_req_(reqN[2]), .m3_req_(reqN[3]),
    .m0_grnt_(g0), .m1_grnt_(g1), .m2_grnt_(g2), .m3_grnt_(g3),
    .s_as_(asN), .s_rdy_(rdyN), .owner(dutOwner), .busy(dutBusy)
  );

  assign grantN = {g3, g2, g1, g0};

  always #5 clk = ~clk;

  function automatic int rrPick(bit [3:0] req, int from, bit skipFrom);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (from + k) % 4;
      if (!(skipFrom && c == from) && req[c]) return c;
    end
    return -1;
  endfunction

  // Reference model: next state straight from the arbitration rules.
  always @(posedge clk) begin
    automatic bit [3:0] req = ~reqN;
    automatic int w;
    automatic bit nBusy = mBusy;
    automatic int nOwner = mOwner;
    automatic int nLast = mLast;
    automatic int nHold = mHold;
    automatic bit nPending;
    nPending = !rdyN ? 1'b0 : (!asN ? 1'b1 : mPending);
    if (!rstN) begin
      nBusy = 0; nOwner = 0; nLast = 3; nHold = 0; nPending = 0;
    end else if (!mBusy) begin
      w = rrPick(req, mLast, 1'b0);
      if (w >= 0) begin nBusy = 1; nOwner = w; nLast = w; nHold = 0; end
    end else if (!req[mOwner]) begin
      w = rrPick(req, mOwner, 1'b1);
      nHold = 0;
      if (w >= 0) begin nOwner = w; nLast = w; end
      else nBusy = 0;
    end else begin
      w = rrPick(req, mOwner, 1'b1);
      if (mHold >= MAX_HOLD - 1 && w >= 0 && !mPending && asN) begin
        nOwner = w; nLast = w; nHold = 0;
      end else begin
        nHold = (mHold + 1 > 255) ? 255 : mHold + 1;
      end
    end
    mBusy    <= nBusy;
    mOwner   <= nOwner;
    mLast    <= nLast;
    mHold    <= nHold;
    mPending <= nPending;
  end

  always @(negedge clk) begin
    if (chkEn) begin
      automatic logic [3:0] expN = mBusy ? 4'(15 - (1 << mOwner)) : 4'hF;
      totalCount++;
      if (grantN !== expN) begin
        badCount++;
        $display("[TB] FAIL model_grant t=%0t got=%b want=%b", $time, grantN, expN);
      end
      totalCount++;
      if (dutBusy !== mBusy) begin
        badCount++;
        $display("[TB] FAIL model_busy t=%0t got=%b want=%b", $time, dutBusy, mBusy);
      end
      if (mBusy) begin
        totalCount++;
        if (dutOwner !== 2'(mOwner)) begin
          badCount++;
          $display("[TB] FAIL model_owner t=%0t got=%0d want=%0d", $time, dutOwner, mOwner);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] r, input logic a, input logic d, input logic rs);
    @(negedge clk);
    reqN = r; asN = a; rdyN = d; rstN = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] expN, input logic expBusy,
                             input logic [1:0] expOwner, input bit chkOwner);
    totalCount++;
    if (grantN !== expN || dutBusy !== expBusy) begin
      badCount++;
      $display("[TB] FAIL %s grant/busy got=%b/%b want=%b/%b", name, grantN, dutBusy, expN, expBusy);
    end
    if (chkOwner) begin
      totalCount++;
      if (dutOwner !== expOwner) begin
        badCount++;
        $display("[TB] FAIL %s owner got=%0d want=%0d", name, dutOwner, expOwner);
      end
    end
  endtask

  initial begin
    applyStimulus(4'hF, 1, 1, 0);
    applyStimulus(4'hF, 1, 1, 0);
    chkEn = 1'b1;
    checkOutput("reset", 4'hF, 0, 2'd0, 1);

    applyStimulus(4'b1011, 1, 1, 1);
    checkOutput("single_m2", 4'b1011, 1, 2'd2, 1);
    applyStimulus(4'hF, 1, 1, 1);
    checkOutput("release_idle", 4'hF, 0, 2'd0, 0);

    applyStimulus(4'hF, 1, 1, 0);
    applyStimulus(4'b0000, 1, 1, 1);
    checkOutput("rr_0", 4'b1110, 1, 2'd0, 1);
    applyStimulus(4'b0001, 1, 1, 1);
    checkOutput("rr_1", 4'b1101, 1, 2'd1, 1);
    applyStimulus(4'b0010, 1, 1, 1);
    checkOutput("rr_2", 4'b1011, 1, 2'd2, 1);
    applyStimulus(4'b0100, 1, 1, 1);
    checkOutput("rr_3", 4'b0111, 1, 2'd3, 1);
    applyStimulus(4'b1000, 1, 1, 1);
    checkOutput("rr_wrap0", 4'b1110, 1, 2'd0, 1);
    applyStimulus(4'hF, 1, 1, 1);

    // Preemption after MAX_HOLD cycles of ownership.
    applyStimulus(4'hF, 1, 1, 0);
    applyStimulus(4'b1110, 1, 1, 1);
    for (int i = 0; i < 3; i++) applyStimulus(4'b1100, 1, 1, 1);
    checkOutput("hold_m0", 4'b1110, 1, 2'd0, 1);
    applyStimulus(4'b1100, 1, 1, 1);
    checkOutput("preempt_m1", 4'b1101, 1, 2'd1, 1);
    applyStimulus(4'hF, 1, 1, 1);

    // Address strobe at hold limit blocks preemption until ready clears pending.
    applyStimulus(4'hF, 1, 1, 0);
    applyStimulus(4'b1110, 1, 1, 1);
    for (int i = 0; i < 3; i++) applyStimulus(4'b1100, 1, 1, 1);
    applyStimulus(4'b1100, 0, 1, 1);
    applyStimulus(4'b1100, 1, 1, 1);
    applyStimulus(4'b1100, 1, 1, 1);
    applyStimulus(4'b1100, 1, 0, 1);
    checkOutput("pending_blocks", 4'b1110, 1, 2'd0, 1);
    applyStimulus(4'b1100, 1, 1, 1);
    checkOutput("after_ready", 4'b1101, 1, 2'd1, 1);
    applyStimulus(4'hF, 1, 1, 1);

    // Strobe and ready together leave pending clear.
    applyStimulus(4'hF, 1, 1, 0);
    applyStimulus(4'b1110, 1, 1, 1);
    for (int i = 0; i < 3; i++) applyStimulus(4'b1100, 1, 1, 1);
    applyStimulus(4'b1100, 0, 0, 1);
    checkOutput("as_rdy_same", 4'b1110, 1, 2'd0, 1);
    applyStimulus(4'b1100, 1, 1, 1);
    checkOutput("as_rdy_handover", 4'b1101, 1, 2'd1, 1);
    applyStimulus(4'hF, 1, 1, 1);

    // Long pending transfer drives hold into saturation.
    applyStimulus(4'hF, 1, 1, 0);
    applyStimulus(4'b1110, 1, 1, 1);
    applyStimulus(4'b1100, 0, 1, 1);
    for (int i = 0; i < 270; i++) applyStimulus(4'b1100, 1, 1, 1);
    checkOutput("saturated_hold", 4'b1110, 1, 2'd0, 1);
    applyStimulus(4'b1100, 1, 0, 1);
    applyStimulus(4'b1100, 1, 1, 1);
    checkOutput("saturated_handover", 4'b1101, 1, 2'd1, 1);
    applyStimulus(4'hF, 1, 1, 1);

    // Reset mid-transfer drops the grant; priority restarts at master 0.
    applyStimulus(4'hF, 1, 1, 0);
    applyStimulus(4'b0111, 1, 1, 1);
    checkOutput("m3_owns", 4'b0111, 1, 2'd3, 1);
    applyStimulus(4'b0111, 0, 1, 1);
    applyStimulus(4'b0111, 1, 1, 0);
    checkOutput("midreset", 4'hF, 0, 2'd0, 1);
    applyStimulus(4'b0110, 1, 1, 1);
    checkOutput("post_reset_m0", 4'b1110, 1, 2'd0, 1);
    applyStimulus(4'hF, 1, 1, 1);
    applyStimulus(4'hF, 1, 1, 1);

    chkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
